matvec_engine: RTL

Parametrised matrix-vector multiply engine: it accepts an N_ROWS x N_COLS matrix and an N_COLS vector as one valid/ready element stream, then computes y = A·x on a skewed, systolic row of MAC lanes. Compared with the fixed 8x8 engine it adds a configurable size and operand width, signed or unsigned arithmetic, stream backpressure, and a matrix-reuse mode that reloads only the vector. It sits between the memory fill streamer and the result consumer.

---
 rtl/matvec_pkg.sv | 24 ++
 rtl/matvec_lane.sv | 59 +++++
 rtl/matvec_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector engine.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int acc_width(input int dw, input int n_cols);
        return 2 * dw + $clog2(n_cols);
    endfunction

    // Beats in one full job: the matrix in row-major order, then the vector.
    function automatic int stream_len(input int n_rows, input int n_cols);
        return n_rows * n_cols + n_cols;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matvec_lane.sv
// One MAC lane: holds one matrix row, multiplies the selected element by the
// operand arriving on the B chain and accumulates while enabled.
module matvec_lane
    import matvec_pkg::*;
#(
    parameter int N_COLS = 8,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = acc_width(DW, N_COLS),
    parameter int KW     = idx_width(N_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [KW-1:0]    wr_idx_i,
    input  logic [DW-1:0]    wr_dat_i,
    input  logic [KW-1:0]    rd_idx_i,
    input  logic [DW-1:0]    b_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [ACC_W-1:0] acc_o
);

    // Product width covers both the full 2*DW product and the accumulator,
    // so a modulo-2^PW multiply of extended operands is exact for either mode.
    localparam int PW = (ACC_W > 2 * DW) ? ACC_W : 2 * DW;

    logic [DW-1:0]    row_q [N_COLS];
    logic [DW-1:0]    a_op;
    logic [PW-1:0]    a_ext, b_ext, prod;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COLS; i++) row_q[i] <= '0;
        end else if (wr_en_i) begin
            row_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign a_op  = row_q[rd_idx_i];
    assign a_ext = {{(PW-DW){SIGNED && a_op[DW-1]}}, a_op};
    assign b_ext = {{(PW-DW){SIGNED && b_i[DW-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)     acc_d = '0;
        else if (en_i) acc_d = acc_q + prod[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Streamed matrix-vector multiply y = A*x on a skewed row of MAC lanes.
// Load: one beat per in_valid&&in_ready; compute N_ROWS+N_COLS-1 cycles; stalls on in_valid low.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int N_ROWS = 8,
    parameter int N_COLS = 8,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = acc_width(DW, N_COLS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         reuse_a,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [DW-1:0]                in_data,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         a_valid,
    output logic [N_ROWS-1:0][ACC_W-1:0] results
);

    localparam int NA    = N_ROWS * N_COLS;
    localparam int TOTAL = stream_len(N_ROWS, N_COLS);
    localparam int STEPS = N_ROWS + N_COLS - 1;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int RW    = $clog2(N_ROWS + 1);
    localparam int KW    = idx_width(N_COLS);
    localparam int TW    = $clog2(STEPS + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   ld_cnt_q;
    logic [RW-1:0]   ld_row_q;
    logic [KW-1:0]   ld_col_q;
    logic [TW-1:0]   t_q;
    logic            a_valid_q;
    logic [DW-1:0]   x_q [N_COLS];
    logic [DW-1:0]   b_q [N_ROWS];
    logic [DW-1:0]   b0_d;
    logic            start_job, reuse_job, accept, ld_last, x_phase, col_wrap, last_step;

    assign start_job = start && !clr && (state_q == IDLE || state_q == DONE);
    assign reuse_job = reuse_a && a_valid_q;
    assign accept    = in_valid && in_ready;
    assign ld_last   = accept && (ld_cnt_q == CW'(TOTAL - 1));
    assign x_phase   = (ld_row_q == RW'(N_ROWS));
    assign col_wrap  = (ld_col_q == KW'(N_COLS - 1));
    assign last_step = (t_q == TW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start)     state_d = LOAD;
                LOAD:       if (ld_last)   state_d = COMPUTE;
                COMPUTE:    if (last_step) state_d = DONE;
                default:                   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
            COMPUTE: busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Row/column track the load counter so no divider is needed for addressing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= '0; ld_row_q <= '0; ld_col_q <= '0; t_q <= '0; a_valid_q <= 1'b0;
        end else if (clr) begin
            ld_cnt_q <= '0; ld_row_q <= '0; ld_col_q <= '0; t_q <= '0; a_valid_q <= 1'b0;
        end else if (start_job) begin
            t_q      <= '0;
            ld_col_q <= '0;
            if (reuse_job) begin
                ld_cnt_q <= CW'(NA);
                ld_row_q <= RW'(N_ROWS);
            end else begin
                ld_cnt_q  <= '0;
                ld_row_q  <= '0;
                a_valid_q <= 1'b0;
            end
        end else if (accept) begin
            ld_cnt_q <= ld_cnt_q + CW'(1);
            ld_col_q <= col_wrap ? '0 : ld_col_q + KW'(1);
            if (col_wrap && !x_phase) ld_row_q <= ld_row_q + RW'(1);
            if (ld_last) a_valid_q <= 1'b1;
        end else if (state_q == COMPUTE && !last_step) begin
            t_q <= t_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COLS; i++) x_q[i] <= '0;
        end else if (accept && x_phase) begin
            x_q[ld_col_q] <= in_data;
        end
    end

    // b_q[0] holds x[t] during step t, so it is primed with x[0] on the last beat.
    always_comb begin
        b0_d = '0;
        if (ld_last)                         b0_d = (N_COLS == 1) ? in_data : x_q[0];
        else if (int'(t_q) + 1 < N_COLS)     b0_d = x_q[KW'(int'(t_q) + 1)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_ROWS; r++) b_q[r] <= '0;
        end else if (clr || start_job) begin
            for (int r = 0; r < N_ROWS; r++) b_q[r] <= '0;
        end else if (ld_last || state_q == COMPUTE) begin
            b_q[0] <= b0_d;
            for (int r = 1; r < N_ROWS; r++) b_q[r] <= b_q[r-1];
        end
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
        logic          lane_en;
        logic [KW-1:0] k_idx;

        assign lane_en = (state_q == COMPUTE) && (int'(t_q) >= r) && (int'(t_q) < r + N_COLS);
        assign k_idx   = KW'(int'(t_q) - r);

        matvec_lane #(
            .N_COLS (N_COLS),
            .DW     (DW),
            .SIGNED (SIGNED),
            .ACC_W  (ACC_W),
            .KW     (KW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (accept && (ld_row_q == RW'(r))),
            .wr_idx_i (ld_col_q),
            .wr_dat_i (in_data),
            .rd_idx_i (k_idx),
            .b_i      (b_q[r]),
            .en_i     (lane_en),
            .clr_i    (clr || start_job),
            .acc_o    (results[r])
        );
    end

    assign a_valid = a_valid_q;

endmodule
